// File: rtl/des_pkg.sv
// Shared definitions for the DES byte-to-block front end.
//   DES_BLOCK_BYTES : bytes per 64-bit DES block.
//   des_if_state_t  : FILL -> LOAD -> WAIT -> DRAIN -> ACK state encoding.
package des_pkg;

    localparam int unsigned DES_BLOCK_BYTES = 8;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_LOAD,
        ST_WAIT,
        ST_DRAIN,
        ST_ACK
    } des_if_state_t;

endpackage

// File: rtl/des_block_interface_if.sv
// Signal bundle between the byte front end, the encryptor core and the
// USB byte path.
//   rx_*            : incoming byte stream (valid/ready) plus flush request
//   rcv_data*       : assembled block and its strobe towards the core
//   trans_data*     : core result and its valid flag
//   handshake_ack   : result-consumed strobe back to the core
//   tx_*            : outgoing byte stream (valid/ready)
//   busy            : front end is not idle-filling
// Modports: slave = the front end itself, master = its environment.
interface des_block_interface_if;

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_flush;
    logic [63:0] rcv_data;
    logic        rcv_data_ready;
    logic [63:0] trans_data;
    logic        trans_data_ready;
    logic        handshake_ack;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    modport slave (
        input  rx_byte, rx_valid, rx_flush, trans_data, trans_data_ready, tx_ready,
        output rx_ready, rcv_data, rcv_data_ready, handshake_ack, tx_byte, tx_valid, busy
    );

    modport master (
        output rx_byte, rx_valid, rx_flush, trans_data, trans_data_ready, tx_ready,
        input  rx_ready, rcv_data, rcv_data_ready, handshake_ack, tx_byte, tx_valid, busy
    );

endinterface

// File: rtl/des_block_interface.sv
// Byte-to-block front end for the DES encryptor core.
// Packs eight bytes (first byte = MSB) into rcv_data, strobes rcv_data_ready,
// waits for the core result, streams it out MSB first over tx valid/ready,
// then pulses handshake_ack.
//   clk   : system clock, rising edge
//   n_rst : asynchronous reset, asserted high (name kept from the codebase)
//   bus   : des_block_interface_if.slave, all data/handshake signals
// rx_ready, tx_valid and busy are decoded from state; all other outputs are
// registered.
module des_block_interface
    import des_pkg::*;
#(
    parameter int unsigned NUM_BYTES = DES_BLOCK_BYTES
) (
    input  logic                   clk,
    input  logic                   n_rst,
    des_block_interface_if.slave   bus
);

    des_if_state_t state, state_next;

    logic [2:0]                  cnt;
    logic [2:0]                  tx_idx;
    logic [63:0]                 out_reg;
    // Byte 0 sits at index 0, i.e. the most significant byte of the block.
    logic [0:NUM_BYTES-1][7:0]   rcv_bytes;
    logic [0:NUM_BYTES-1][7:0]   rcv_bytes_next;
    logic                        rcv_data_ready_q;
    logic                        handshake_ack_q;

    logic                        accept;
    logic [3:0]                  fill_after;
    logic                        block_full;
    logic                        flush_go;
    logic                        tx_fire;
    logic                        drain_last;

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        bus.rx_ready = 1'b0;
        bus.tx_valid = 1'b0;
        bus.busy     = 1'b1;
        accept       = 1'b0;
        fill_after   = {1'b0, cnt};
        block_full   = 1'b0;
        flush_go     = 1'b0;
        tx_fire      = 1'b0;
        drain_last   = 1'b0;

        case (state)
            ST_FILL: begin
                bus.rx_ready = ~n_rst;
                bus.busy     = 1'b0;
                accept       = bus.rx_valid;
                // Count including this cycle's byte; bit 3 is the terminal flag.
                fill_after   = {1'b0, cnt} + {3'b000, accept};
                block_full   = fill_after[3];
                // An empty block ignores flush; a full one takes the normal path.
                flush_go     = bus.rx_flush && (fill_after != 4'd0) && !fill_after[3];
                if (block_full || flush_go) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.trans_data_ready) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                bus.tx_valid = 1'b1;
                tx_fire      = bus.tx_ready;
                drain_last   = tx_fire && (tx_idx == 3'd7);
                if (drain_last) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                state_next = ST_FILL;
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    // Next block contents during FILL: write the accepted byte, and on flush
    // zero every lane at or beyond the fill count.
    always_comb begin
        rcv_bytes_next = rcv_bytes;
        if (accept) begin
            rcv_bytes_next[cnt] = bus.rx_byte;
        end
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (flush_go && (4'(i) >= fill_after)) begin
                rcv_bytes_next[3'(i)] = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            cnt              <= '0;
            tx_idx           <= '0;
            out_reg          <= '0;
            rcv_bytes        <= '0;
            rcv_data_ready_q <= 1'b0;
            handshake_ack_q  <= 1'b0;
        end else begin
            rcv_data_ready_q <= (state == ST_FILL) && (state_next == ST_LOAD);
            handshake_ack_q  <= drain_last;
            case (state)
                ST_FILL: begin
                    rcv_bytes <= rcv_bytes_next;
                    if (accept) begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_WAIT: begin
                    if (bus.trans_data_ready) begin
                        out_reg <= bus.trans_data;
                        tx_idx  <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (tx_fire) begin
                        out_reg <= {out_reg[55:0], 8'h00};
                        tx_idx  <= tx_idx + 3'd1;
                    end
                end
                ST_ACK: begin
                    cnt       <= '0;
                    rcv_bytes <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rcv_data       = rcv_bytes;
    assign bus.rcv_data_ready = rcv_data_ready_q;
    assign bus.handshake_ack  = handshake_ack_q;
    assign bus.tx_byte        = out_reg[63:56];

endmodule

// File: tb/tb_des_block_interface.sv
// Self-checking bench for des_block_interface: table of whole-block
// transactions plus hand-written reset / empty-flush / spurious-strobe checks.
module tb_des_block_interface;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    des_block_interface_if bus ();

    des_block_interface #(.NUM_BYTES(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct {
        int unsigned nbytes;       // bytes fed, left-aligned in 'bytes'
        logic [63:0] bytes;
        int unsigned flush_mode;   // 0 none, 1 with last byte, 2 separate cycle
        logic [63:0] exp_rcv;
        logic [63:0] result;
        logic        bp;           // tx_ready pattern 1,0,0 repeating
        int unsigned abort_after;  // reset after this many tx bytes (8 = never)
    } blk_vec_t;

    blk_vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.rx_byte          = 8'h00;
        bus.rx_valid         = 1'b0;
        bus.rx_flush         = 1'b0;
        bus.trans_data       = 64'h0;
        bus.trans_data_ready = 1'b0;
        bus.tx_ready         = 1'b0;
    endtask

    task automatic run_block(input blk_vec_t v);
        logic [63:0] b;
        logic [63:0] r;
        logic [7:0]  held;
        logic        stalled;
        int unsigned got;
        int unsigned cyc;

        b = v.bytes;
        for (int unsigned i = 0; i < v.nbytes; i++) begin
            @(negedge clk);
            chk("rx_ready_fill", 64'(bus.rx_ready), 64'd1);
            bus.rx_valid = 1'b1;
            bus.rx_byte  = b[63:56];
            b            = b << 8;
            bus.rx_flush = (v.flush_mode == 1) && (i == v.nbytes - 1);
        end
        if (v.flush_mode == 2) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.rx_flush = 1'b1;
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_flush = 1'b0;
        chk("rcv_data_ready_strobe", 64'(bus.rcv_data_ready), 64'd1);
        chk("rcv_data", bus.rcv_data, v.exp_rcv);

        @(negedge clk);
        chk("rcv_data_ready_one_cycle", 64'(bus.rcv_data_ready), 64'd0);
        chk("busy_wait", 64'(bus.busy), 64'd1);
        repeat (15) @(negedge clk);
        chk("tx_valid_in_wait", 64'(bus.tx_valid), 64'd0);
        chk("rcv_data_held", bus.rcv_data, v.exp_rcv);
        bus.trans_data_ready = 1'b1;
        bus.trans_data       = v.result;

        @(negedge clk);
        bus.trans_data_ready = 1'b0;
        bus.trans_data       = 64'h0;
        chk("tx_valid_latency", 64'(bus.tx_valid), 64'd1);

        r       = v.result;
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = 8'h00;
        while (got < 8 && cyc < 64) begin
            if (stalled) begin
                chk("tx_byte_stable", 64'(bus.tx_byte), 64'(held));
            end
            if (got == v.abort_after) begin
                break;
            end
            bus.tx_ready = v.bp ? (cyc % 3 == 0) : 1'b1;
            if (bus.tx_valid && bus.tx_ready) begin
                chk("tx_byte", 64'(bus.tx_byte), 64'(r[63:56]));
                r       = r << 8;
                got++;
                stalled = 1'b0;
            end else begin
                stalled = bus.tx_valid;
                held    = bus.tx_byte;
            end
            cyc++;
            @(negedge clk);
        end
        bus.tx_ready = 1'b0;

        if (v.abort_after < 8) begin
            chk("tx_count_before_reset", 64'(got), 64'(v.abort_after));
            chk("tx_valid_before_reset", 64'(bus.tx_valid), 64'd1);
            n_rst = 1'b1;
            #1;
            chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_tx_byte", 64'(bus.tx_byte), 64'd0);
            chk("rst_rcv_data", bus.rcv_data, 64'd0);
            chk("rst_rcv_data_ready", 64'(bus.rcv_data_ready), 64'd0);
            chk("rst_handshake_ack", 64'(bus.handshake_ack), 64'd0);
            @(negedge clk);
            n_rst = 1'b0;
            @(negedge clk);
            chk("rx_ready_after_reset", 64'(bus.rx_ready), 64'd1);
            chk("handshake_ack_after_reset", 64'(bus.handshake_ack), 64'd0);
        end else begin
            chk("tx_transfers", 64'(got), 64'd8);
            chk("handshake_ack", 64'(bus.handshake_ack), 64'd1);
            chk("tx_valid_in_ack", 64'(bus.tx_valid), 64'd0);
            chk("rx_ready_in_ack", 64'(bus.rx_ready), 64'd0);
            @(negedge clk);
            chk("handshake_ack_one_cycle", 64'(bus.handshake_ack), 64'd0);
            chk("rx_ready_after_ack", 64'(bus.rx_ready), 64'd1);
            chk("busy_after_ack", 64'(bus.busy), 64'd0);
            chk("rcv_data_cleared", bus.rcv_data, 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8, 64'h0102030405060708, 0, 64'h0102030405060708, 64'hA1B2C3D4E5F60718, 1'b0, 8};
        vecs[1] = '{2, 64'hAABB000000000000, 2, 64'hAABB000000000000, 64'h1122334455667788, 1'b0, 8};
        vecs[2] = '{3, 64'h5566770000000000, 1, 64'h5566770000000000, 64'h0F1E2D3C4B5A6978, 1'b1, 8};
        vecs[3] = '{8, 64'hC0C1C2C3C4C5C6C7, 0, 64'hC0C1C2C3C4C5C6C7, 64'h0123456789ABCDEF, 1'b1, 8};
        vecs[4] = '{8, 64'h2122232425262728, 1, 64'h2122232425262728, 64'hFEDCBA9876543210, 1'b0, 8};
        vecs[5] = '{8, 64'h3132333435363738, 0, 64'h3132333435363738, 64'hDEADBEEFCAFEF00D, 1'b1, 3};
        vecs[6] = '{8, 64'h1011121314151617, 0, 64'h1011121314151617, 64'h8877665544332211, 1'b0, 8};

        idle_inputs();
        n_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_rcv_data", bus.rcv_data, 64'd0);
        chk("reset_rcv_data_ready", 64'(bus.rcv_data_ready), 64'd0);
        chk("reset_handshake_ack", 64'(bus.handshake_ack), 64'd0);
        chk("reset_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_tx_byte", 64'(bus.tx_byte), 64'd0);
        n_rst = 1'b0;
        @(negedge clk);
        chk("rx_ready_after_release", 64'(bus.rx_ready), 64'd1);

        // Flush with nothing buffered must not start a block.
        bus.rx_flush = 1'b1;
        @(negedge clk);
        bus.rx_flush = 1'b0;
        chk("empty_flush_no_strobe", 64'(bus.rcv_data_ready), 64'd0);
        chk("empty_flush_not_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("empty_flush_no_strobe_2", 64'(bus.rcv_data_ready), 64'd0);
        chk("empty_flush_rx_ready", 64'(bus.rx_ready), 64'd1);

        // Core strobe while filling must be ignored.
        bus.trans_data_ready = 1'b1;
        bus.trans_data       = 64'hFFEEDDCCBBAA9988;
        @(negedge clk);
        idle_inputs();
        chk("spurious_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("spurious_busy", 64'(bus.busy), 64'd0);
        chk("spurious_tx_byte", 64'(bus.tx_byte), 64'd0);
        @(negedge clk);
        chk("spurious_tx_valid_2", 64'(bus.tx_valid), 64'd0);

        for (int unsigned k = 0; k < 7; k++) begin
            run_block(vecs[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
